// File: rtl/bitonic_sorter_pkg.sv
// Shared types for the bitonic sorter and its controller: muon candidate layout,
// controller state encoding and helpers to move muons in and out of flat slot vectors.
package bitonic_sorter_pkg;

  localparam int PT_WIDTH   = 9;
  localparam int IDX_WIDTH  = 4;
  localparam int MUON_WIDTH = PT_WIDTH + IDX_WIDTH;

  // pt occupies the low bits of a flat slot, idx sits above it.
  typedef struct packed {
    logic [IDX_WIDTH-1:0] idx;
    logic [PT_WIDTH-1:0]  pt;
  } muon_t;

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    UNLOAD = 2'd3
  } ctrl_state_e;

  function automatic muon_t make_muon(input logic [PT_WIDTH-1:0] pt,
                                      input logic [IDX_WIDTH-1:0] idx);
    muon_t m;
    m.pt  = pt;
    m.idx = idx;
    return m;
  endfunction

  function automatic logic [MUON_WIDTH-1:0] pack_muon(input muon_t m);
    return m;
  endfunction

  function automatic muon_t unpack_muon(input logic [MUON_WIDTH-1:0] s);
    return muon_t'(s);
  endfunction

endpackage

// File: rtl/sort_order_checker.sv
// Flags any ascending adjacent pair among the first CHK_NUM slots of a sorted
// frame; only instantiated when SORTER_CHECK_EN is defined.
module sort_order_checker
  import bitonic_sorter_pkg::*;
#(
  parameter int CAND_NUM = 16,
  parameter int CHK_NUM  = 5
) (
  input  logic [CAND_NUM*MUON_WIDTH-1:0] frame,
  output logic                           order_err
);

  muon_t a_m;
  muon_t b_m;

  always_comb begin
    order_err = 1'b0;
    a_m       = '0;
    b_m       = '0;
    for (int k = 0; k < CHK_NUM - 1; k++) begin
      a_m = unpack_muon(frame[k*MUON_WIDTH +: MUON_WIDTH]);
      b_m = unpack_muon(frame[(k+1)*MUON_WIDTH +: MUON_WIDTH]);
      if (a_m.pt < b_m.pt) order_err = 1'b1;
    end
  end

endmodule

// File: rtl/bitonic_sort_ctrl.sv
// Load / launch / wait / unload sequencer in front of the bitonic sorter.
// Define SORTER_CHECK_EN to build the sticky sort-order checker behind sort_err.
module bitonic_sort_ctrl
  import bitonic_sorter_pkg::*;
#(
  parameter int CAND_NUM = 16,
  parameter int OUT_NUM  = 4,
  parameter int SORT_LAT = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [PT_WIDTH-1:0]            in_pt,
  input  logic                           in_last,
  output logic [CAND_NUM*MUON_WIDTH-1:0] srt_m,
  output logic                           srt_start,
  input  logic [CAND_NUM*MUON_WIDTH-1:0] srt_q,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [PT_WIDTH-1:0]            out_pt,
  output logic [IDX_WIDTH-1:0]           out_idx,
  output logic [IDX_WIDTH-1:0]           out_rank,
  output logic                           out_last,
  output logic [15:0]                    frames_done,
  output logic                           sort_err
);

  localparam int FW    = CAND_NUM * MUON_WIDTH;
  localparam int LAT_W = $clog2(SORT_LAT + 1) + 1;
  localparam logic [IDX_WIDTH-1:0] LAST_SLOT = IDX_WIDTH'(CAND_NUM - 1);
  localparam logic [IDX_WIDTH-1:0] LAST_RANK = IDX_WIDTH'(OUT_NUM - 1);
  localparam logic [LAT_W-1:0]     LAT_END   = LAT_W'(SORT_LAT);

  // Handshakes: a beat transfers on the rising edge where valid && ready; the
  // sender holds its payload stable while valid is high and ready is low.
  ctrl_state_e state_q, state_d;
  logic [IDX_WIDTH-1:0] slot_q, slot_d;
  logic [LAT_W-1:0]     lat_q, lat_d;
  logic [IDX_WIDTH-1:0] rank_q, rank_d;
  logic                 in_ready_q, in_ready_d;
  logic                 srt_start_q, srt_start_d;
  logic [FW-1:0]        srt_m_q, srt_m_d;
  logic [FW-1:0]        cap_q, cap_d;
  logic                 out_valid_q, out_valid_d;
  logic [PT_WIDTH-1:0]  out_pt_q, out_pt_d;
  logic [IDX_WIDTH-1:0] out_idx_q, out_idx_d;
  logic [IDX_WIDTH-1:0] out_rank_q, out_rank_d;
  logic                 out_last_q, out_last_d;
  logic [15:0]          frames_done_q, frames_done_d;

  logic                 accept;
  logic                 out_hs;
  logic [IDX_WIDTH-1:0] rank_nxt;
  muon_t                head_m;
  muon_t                nxt_m;

  always_comb begin
    state_d       = state_q;
    slot_d        = slot_q;
    lat_d         = lat_q;
    rank_d        = rank_q;
    in_ready_d    = in_ready_q;
    srt_start_d   = srt_start_q;
    srt_m_d       = srt_m_q;
    cap_d         = cap_q;
    out_valid_d   = out_valid_q;
    out_pt_d      = out_pt_q;
    out_idx_d     = out_idx_q;
    out_rank_d    = out_rank_q;
    out_last_d    = out_last_q;
    frames_done_d = frames_done_q;

    accept   = in_valid && in_ready_q;
    out_hs   = out_valid_q && out_ready;
    rank_nxt = rank_q + 1'b1;
    head_m   = unpack_muon(srt_q[MUON_WIDTH-1:0]);
    nxt_m    = unpack_muon(cap_q[int'(rank_nxt)*MUON_WIDTH +: MUON_WIDTH]);

    case (state_q)
      LOAD: begin
        if (accept) begin
          srt_m_d[int'(slot_q)*MUON_WIDTH +: MUON_WIDTH] = pack_muon(make_muon(in_pt, slot_q));
          slot_d = slot_q + 1'b1;
          if (slot_q == LAST_SLOT || in_last) begin
            // Unfilled slots sort to the bottom with pt 0 and keep their own index.
            for (int j = 0; j < CAND_NUM; j++) begin
              if (j > int'(slot_q))
                srt_m_d[j*MUON_WIDTH +: MUON_WIDTH] = pack_muon(make_muon('0, IDX_WIDTH'(j)));
            end
            slot_d      = '0;
            in_ready_d  = 1'b0;
            srt_start_d = 1'b1;
            state_d     = LAUNCH;
          end
        end
      end
      LAUNCH: begin
        srt_start_d = 1'b0;
        lat_d       = LAT_W'(1);
        state_d     = WAIT;
      end
      WAIT: begin
        if (lat_q == LAT_END) begin
          cap_d       = srt_q;
          rank_d      = '0;
          out_valid_d = 1'b1;
          out_pt_d    = head_m.pt;
          out_idx_d   = head_m.idx;
          out_rank_d  = '0;
          out_last_d  = (LAST_RANK == '0);
          state_d     = UNLOAD;
        end else begin
          lat_d = lat_q + 1'b1;
        end
      end
      UNLOAD: begin
        if (out_hs) begin
          if (out_last_q) begin
            out_valid_d   = 1'b0;
            out_pt_d      = '0;
            out_idx_d     = '0;
            out_rank_d    = '0;
            out_last_d    = 1'b0;
            rank_d        = '0;
            frames_done_d = frames_done_q + 16'd1;
            in_ready_d    = 1'b1;
            state_d       = LOAD;
          end else begin
            rank_d     = rank_nxt;
            out_pt_d   = nxt_m.pt;
            out_idx_d  = nxt_m.idx;
            out_rank_d = rank_nxt;
            out_last_d = (rank_nxt == LAST_RANK);
          end
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= LOAD;
      slot_q        <= '0;
      lat_q         <= '0;
      rank_q        <= '0;
      in_ready_q    <= 1'b1;
      srt_start_q   <= 1'b0;
      srt_m_q       <= '0;
      cap_q         <= '0;
      out_valid_q   <= 1'b0;
      out_pt_q      <= '0;
      out_idx_q     <= '0;
      out_rank_q    <= '0;
      out_last_q    <= 1'b0;
      frames_done_q <= '0;
    end else begin
      state_q       <= state_d;
      slot_q        <= slot_d;
      lat_q         <= lat_d;
      rank_q        <= rank_d;
      in_ready_q    <= in_ready_d;
      srt_start_q   <= srt_start_d;
      srt_m_q       <= srt_m_d;
      cap_q         <= cap_d;
      out_valid_q   <= out_valid_d;
      out_pt_q      <= out_pt_d;
      out_idx_q     <= out_idx_d;
      out_rank_q    <= out_rank_d;
      out_last_q    <= out_last_d;
      frames_done_q <= frames_done_d;
    end
  end

`ifdef SORTER_CHECK_EN
  localparam int CHK_NUM = (OUT_NUM + 1 < CAND_NUM) ? OUT_NUM + 1 : CAND_NUM;

  logic chk_err;
  logic capture;
  logic sort_err_q, sort_err_d;

  sort_order_checker #(
    .CAND_NUM (CAND_NUM),
    .CHK_NUM  (CHK_NUM)
  ) u_checker (
    .frame     (srt_q),
    .order_err (chk_err)
  );

  assign capture = (state_q == WAIT) && (lat_q == LAT_END);

  always_comb begin
    sort_err_d = sort_err_q | (capture & chk_err);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sort_err_q <= 1'b0;
    else     sort_err_q <= sort_err_d;
  end

  assign sort_err = sort_err_q;
`else
  assign sort_err = 1'b0;
`endif

  assign in_ready    = in_ready_q;
  assign srt_start   = srt_start_q;
  assign srt_m       = srt_m_q;
  assign out_valid   = out_valid_q;
  assign out_pt      = out_pt_q;
  assign out_idx     = out_idx_q;
  assign out_rank    = out_rank_q;
  assign out_last    = out_last_q;
  assign frames_done = frames_done_q;

endmodule

// File: doc/bitonic_sort_ctrl.md
Name: bitonic_sort_ctrl

Overview:
Sequencer for the bitonic sorter datapath.
- Collects up to CAND_NUM muon candidates one per cycle over a valid/ready stream and stamps each with its slot index.
- Pads short frames, launches one sort, and waits a fixed SORT_LAT.
- Captures the sorted frame and streams the top OUT_NUM candidates out, highest pt first.
- Sits between the candidate source and the bitonic_sort instance; it is the only driver of the sorter inputs.

Parameters:
- CAND_NUM, 16: sorter width, candidates per frame; power of 2, must equal 2**IDX_WIDTH.
- OUT_NUM, 4: sorted candidates emitted per frame; 1..CAND_NUM.
- SORT_LAT, 2: cycles from srt_start to valid srt_q; must be >= 1.

Ports:
- clk, in, 1: logic clock.
- rst, in, 1: asynchronous active-high reset.
- in_valid, in, 1: candidate valid.
- in_ready, out, 1: controller accepts a candidate.
- in_pt, in, PT_WIDTH: candidate pt.
- in_last, in, 1: closes the frame after this candidate.
- srt_m, out, CAND_NUM*MUON_WIDTH: sorter input; slot i is bits [i*MUON_WIDTH +: MUON_WIDTH], pt in the low bits, idx above.
- srt_start, out, 1: one-cycle launch pulse.
- srt_q, in, CAND_NUM*MUON_WIDTH: sorter output, same packing; slot 0 holds the highest pt.
- out_valid, out, 1: sorted candidate valid.
- out_ready, in, 1: downstream accepts.
- out_pt, out, PT_WIDTH: sorted pt.
- out_idx, out, IDX_WIDTH: original slot of the candidate.
- out_rank, out, IDX_WIDTH: rank 0..OUT_NUM-1.
- out_last, out, 1: asserted with rank OUT_NUM-1.
- frames_done, out, 16: completed-frame counter.
- sort_err, out, 1: sticky sort-order error.

Behaviour:
- Reset values (applied immediately on rst):
  - state = LOAD, slot/latency/rank counters = 0.
  - in_ready = 1, srt_start = 0, srt_m = 0.
  - out_valid = 0, out_pt/out_idx/out_rank/out_last = 0.
  - frames_done = 0, sort_err = 0.
- FSM states: LOAD -> LAUNCH -> WAIT -> UNLOAD -> LOAD.
- LOAD:
  - in_ready = 1.
  - On in_valid&&in_ready, slot s = slot counter gets pt = in_pt and idx = s.
  - The slot counter increments.
  - The frame closes on an accepted candidate when s == CAND_NUM-1 or in_last = 1; the state goes to LAUNCH.
- Padding: when a frame closes at slot s < CAND_NUM-1, slots s+1..CAND_NUM-1 are written pt = 0, idx = own slot, at the same edge.
- in_last with s == CAND_NUM-1 behaves exactly as a full frame.
- in_ready is 0 in every state except LOAD.
- LAUNCH: srt_start = 1 for exactly one cycle; the latency counter loads 1; the state goes to WAIT.
- srt_m holds its value from frame close until the next frame's first accept.
- WAIT:
  - The latency counter increments each cycle.
  - If srt_start was high in cycle S, srt_q is registered at the end of cycle S+SORT_LAT.
  - The state then goes to UNLOAD with rank = 0.
- UNLOAD:
  - out_valid = 1 and out_rank = rank.
  - out_pt and out_idx come from captured slot rank.
  - out_last = (rank == OUT_NUM-1).
  - While out_ready = 0, all out_* signals hold stable.
  - On handshake rank increments.
  - On the handshake with out_last: frames_done += 1 (wraps at 2**16), state goes to LOAD, and in_ready = 1 in the next cycle.
- Frame-close to first out_valid: SORT_LAT+2 cycles.
- Equal pt values are ordered as the sorter delivers them; the controller does not re-order.
- An asserted rst in any state aborts the frame; no partial output is emitted.
- in_valid outside LOAD is ignored. The source must hold the candidate until in_ready.

Optional Feature:
- Macro SORTER_CHECK_EN.
- Defined: at srt_q capture, any adjacent pair in the first OUT_NUM+1 slots (capped at CAND_NUM) with pt[k] < pt[k+1] sets sort_err. sort_err stays 1 until rst.
- Undefined: sort_err is tied to 0 and no comparators are built.
- The port list is identical in both builds.

Decomposition:
- bitonic_sorter_pkg gains:
  - MUON_WIDTH = PT_WIDTH+IDX_WIDTH;
  - the ctrl state enum (LOAD, LAUNCH, WAIT, UNLOAD);
  - pack/unpack functions between muon_t and flat slots.
- Existing muon_t, PT_WIDTH and IDX_WIDTH are reused.
- Sub-module sort_order_checker holds the comparator chain; it is instantiated only under SORTER_CHECK_EN.

Test Plan:
- Full frame: pts 0..15 sent back-to-back, out_ready = 1, with a reference descending sorter of latency 2. Expect srt_start high exactly 1 cycle. Expect outputs (15,idx15,rank0), (14,14,1), (13,13,2), (12,12,3,last). Expect frames_done = 1 and first out_valid 4 cycles after the close.
- Short frame: 3 candidates pt 5,9,2 with in_last on the third. Expect srt_m slots 3..15 = pt0/idx=slot. Expect outputs (9,1), (5,0), (2,2), (0,idx in 3..15).
- Backpressure: out_ready low for 5 cycles at rank 1. Expect outputs stable, in_ready = 0 throughout, no rank skip.
- Reset mid-WAIT: assert rst one cycle after srt_start. Expect out_valid = 0, in_ready = 1 after release, frames_done unchanged, and a new frame sorts correctly.
- Checker (SORTER_CHECK_EN): a faulty sorter model swaps slots 0 and 1. Expect sort_err = 1 at capture and sticky through the next good frame. In the undefined build sort_err stays 0.
- Counter wrap: preload or run 65536 frames. Expect frames_done 0xFFFF -> 0x0000.
